booth_mul4: RTL and testbench
=============================

Name: booth_mul4

Overview:
- Sequential signed 4x4 radix-2 Booth multiplier.
- Sits directly upstream of the team's 4-bit add/sub datapath (add_subb). It drives that block's operands and mode each iteration, then consumes s/cout/v to form the next partial product.
- Produces an 8-bit two's-complement product after a fixed number of cycles, under a start/done handshake.
- Serves as the multiply stage of the small ALU built around add_subb.

Parameters:
- None. Width is fixed at 4 by the add/sub datapath; the iteration count is fixed at 4.

Ports:
- clk    input   1  rising-edge clock
- rst    input   1  asynchronous active-high reset
- start  input   1  request; sampled only in IDLE
- a      input   4  multiplicand, signed two's complement; captured when start is accepted
- b      input   4  multiplier, signed two's complement; captured when start is accepted
- busy   output  1  high while an operation is in progress
- done   output  1  one-cycle pulse when p is updated
- p      output  8  signed product; holds until the next completion

Behaviour:
- Clock and reset (already decided): one clock, clk; reset rst is asynchronous and active-high.
- Reset values:
  - state=IDLE; busy=0; done=0; p=8'h00.
  - Internal registers cleared: A=0, Q=0, Q_1=0, M=0, cnt=0.
- States: IDLE, RUN.
- IDLE:
  - If start=1 at a clock edge: M<=a, Q<=b, A<=0, Q_1<=0, cnt<=0, busy<=1, state<=RUN.
  - Otherwise hold all registers.
- RUN: one Booth iteration per cycle, four cycles total.
  - Pair {Q[0],Q_1}=01 -> add_subb computes A+M (m=0).
  - Pair 10 -> add_subb computes A-M (m=1).
  - Pair 00 or 11 -> no arithmetic; sum=A, overflow treated as 0.
  - The add_subb instance is purely combinational, fed from registered A/M. The mode input m and the bypass select are derived from Q[0]^Q_1 and Q[0].
- True sign of the sum is sgn = s[3]^v. This is required for M=-8, where A-M overflows 4 bits.
- Arithmetic right shift of {sum,Q,Q_1}:
  - A <= {sgn, sum[3:1]}
  - Q <= {sum[0], Q[3:1]}
  - Q_1 <= Q[0]
- cout of add_subb is unused by this block.
- cnt increments each RUN cycle. On the 4th RUN edge (cnt==3):
  - p <= {A_next, Q_next}, done<=1, busy<=0, state<=IDLE.
- Latency: start accepted at edge E0; done=1 and p valid in the cycle after edge E4, i.e. 4 cycles after acceptance.
- done is high for exactly one cycle. p remains stable until the next completion.
- start while busy=1: ignored; the operation in flight is unaffected, and a and b may change freely.
- start=1 in the cycle done=1: accepted, since the state is already IDLE. Back-to-back throughput is one result per 5 cycles, with busy low for that single cycle.
- start held high continuously: a new operation begins every 5 cycles.
- rst asserted mid-operation:
  - Immediate return to reset values; no done pulse and p cleared.
  - After rst deasserts, the next start behaves normally.
- Result range: -56..+64. All products are representable in 8 bits and no saturation is needed.

Test Plan:
- Reset, then start with a=3, b=5 -> busy=1 for 4 cycles; done pulses once, 4 cycles after acceptance; p=8'h0F.
- a=-8 (4'h8), b=-8 -> p=8'h40 (+64). Exercises the v-corrected sign on A-M overflow.
- a=-8, b=7 -> p=8'hC8 (-56). a=7, b=-1 (4'hF) -> p=8'hF9 (-7). a=0, b=4'hA -> p=8'h00.
- Start a=2, b=3, then pulse start with a=5, b=5 during busy -> single done; p=8'h06. A second start in the done cycle with a=-1, b=-1 -> next done 5 cycles after the first; p=8'h01.
- Start a=6, b=6; assert rst asynchronously mid-cycle on the 2nd RUN cycle -> busy=0, done=0, p=8'h00 immediately. After release, start a=1, b=-3 -> p=8'hFD.
- Exhaustive: all 256 (a,b) pairs, back-to-back starts -> each p equals the signed product. done count equals accepted starts.

Source files
------------

// File: rtl/booth_mul4.sv
// Sequential signed 4x4 radix-2 Booth multiplier built around the 4-bit add/sub
// datapath; one Booth step per clock, four steps per product.

module add_subb (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       m,
    output logic [3:0] s,
    output logic       cout,
    output logic       v
);
    logic [3:0] b_eff;

    // m=1 selects a-b as a + ~b + 1.
    assign b_eff     = b ^ {4{m}};
    assign {cout, s} = {1'b0, a} + {1'b0, b_eff} + {4'b0000, m};
    assign v         = (a[3] == b_eff[3]) && (s[3] != a[3]);
endmodule

module booth_mul4 (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       busy,
    output logic       done,
    output logic [7:0] p
);
    // Handshake: start is sampled only while idle (busy=0); the edge that sees
    // start=1 captures a/b. done pulses for one cycle when p updates; p then
    // holds until the next completion. start during busy is ignored.
    typedef enum logic {IDLE, RUN} state_t;

    state_t     state_q, state_d;
    logic [3:0] acc_q, acc_d;
    logic [3:0] q_q, q_d;
    logic       q_1_q, q_1_d;
    logic [3:0] m_q, m_d;
    logic [1:0] cnt_q, cnt_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] p_q, p_d;

    logic [3:0] s;
    logic       v;
    logic       cout_unused;
    logic       do_arith;
    logic [3:0] sum;
    logic       sgn;

    // Pair 10 subtracts, 01 adds; 00/11 bypass the adder entirely.
    assign do_arith = q_q[0] ^ q_1_q;

    add_subb u_add_subb (
        .a    (acc_q),
        .b    (m_q),
        .m    (q_q[0]),
        .s    (s),
        .cout (cout_unused),
        .v    (v)
    );

    assign sum = do_arith ? s : acc_q;
    // Sign of the true 5-bit result; needed when A-M overflows (M=-8).
    assign sgn = sum[3] ^ (do_arith & v);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        q_d     = q_q;
        q_1_d   = q_1_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        p_d     = p_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    m_d     = a;
                    q_d     = b;
                    acc_d   = 4'h0;
                    q_1_d   = 1'b0;
                    cnt_d   = 2'd0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = {sgn, sum[3:1]};
                q_d   = {sum[0], q_q[3:1]};
                q_1_d = q_q[0];
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    p_d     = {acc_d, q_d};
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= 4'h0;
            q_q     <= 4'h0;
            q_1_q   <= 1'b0;
            m_q     <= 4'h0;
            cnt_q   <= 2'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            p_q     <= 8'h00;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            q_1_q   <= q_1_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            p_q     <= p_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign p    = p_q;
endmodule

// File: tb/tb_booth_mul4.sv
// Self-checking bench for booth_mul4: directed table, handshake corner cases,
// async reset mid-operation, random pairs and an exhaustive back-to-back sweep.

module tb_booth_mul4;
    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] p;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp_p;
    } vec_t;

    vec_t vecs[6];

    booth_mul4 dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain signed multiplication
    function automatic logic [7:0] ref_mul(input logic [3:0] x, input logic [3:0] y);
        int xi;
        int yi;
        int r;
        xi = $signed(x);
        yi = $signed(y);
        r  = xi * yi;
        return r[7:0];
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Driver: start one op from idle, wait for done (bounded), return p and latency.
    task automatic do_op(input logic [3:0] ta, input logic [3:0] tb,
                         output logic [7:0] rp, output int lat);
        @(negedge clk);
        a = ta;
        b = tb;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = 4'($urandom);
        b = 4'($urandom);
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        rp = p;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 20) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        logic [7:0] rp;
        int lat;
        int cyc;

        vecs[0] = '{4'h3, 4'h5, 8'h0F};
        vecs[1] = '{4'h8, 4'h8, 8'h40};
        vecs[2] = '{4'h8, 4'h7, 8'hC8};
        vecs[3] = '{4'h7, 4'hF, 8'hF9};
        vecs[4] = '{4'h0, 4'hA, 8'h00};
        vecs[5] = '{4'hF, 4'h8, 8'h08};

        rst = 1'b1;
        start = 1'b0;
        a = 4'h0;
        b = 4'h0;
        #2;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_p", p, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 6; i++) begin
            do_op(vecs[i].a, vecs[i].b, rp, lat);
            chk($sformatf("vec%0d_p", i), rp, vecs[i].exp_p);
            chk($sformatf("vec%0d_latency", i), lat, 4);
            chk($sformatf("vec%0d_busy_at_done", i), busy, 0);
            @(negedge clk);
            chk($sformatf("vec%0d_done_one_cycle", i), done, 0);
            chk($sformatf("vec%0d_p_holds", i), p, vecs[i].exp_p);
        end

        // start during busy ignored; start in done cycle accepted
        @(negedge clk);
        a = 4'h2;
        b = 4'h3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_accept", busy, 1);
        @(negedge clk);
        a = 4'h5;
        b = 4'h5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 4'($urandom);
        b = 4'($urandom);
        wait_done(cyc);
        chk("ignore_start_latency", cyc, 2);
        chk("ignore_start_p", p, 8'h06);
        a = 4'hF;
        b = 4'hF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", busy, 1);
        chk("b2b_done_dropped", done, 0);
        a = 4'($urandom);
        b = 4'($urandom);
        wait_done(cyc);
        chk("b2b_interval", cyc + 1, 5);
        chk("b2b_p", p, 8'h01);

        // Async reset in the 2nd RUN cycle
        @(negedge clk);
        a = 4'h6;
        b = 4'h6;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_p", p, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_idle_done", done, 0);
        do_op(4'h1, 4'hD, rp, lat);
        chk("postrst_p", rp, 8'hFD);
        chk("postrst_latency", lat, 4);

        // Random pairs against the model
        for (int i = 0; i < 40; i++) begin
            logic [3:0] ra;
            logic [3:0] rb;
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            do_op(ra, rb, rp, lat);
            chk($sformatf("rand_%0h_%0h", ra, rb), rp, ref_mul(ra, rb));
        end

        // Exhaustive sweep, start held high, scoreboard queue
        begin
            int idx;
            int dones;
            int last;
            int cc;
            idx = 0;
            dones = 0;
            last = 0;
            cc = 0;
            @(negedge clk);
            while ((idx < 256 || exp_q.size() > 0 || busy) && cc < 3000) begin
                if (done) begin
                    if (exp_q.size() > 0)
                        chk($sformatf("sweep_p_%0d", dones), p, exp_q.pop_front());
                    else
                        chk("sweep_extra_done", 1, 0);
                    if (dones > 0) chk("sweep_interval", cc - last, 5);
                    last = cc;
                    dones++;
                end
                if (!busy && idx < 256) begin
                    a = 4'(idx >> 4);
                    b = 4'(idx);
                    start = 1'b1;
                    exp_q.push_back(ref_mul(4'(idx >> 4), 4'(idx)));
                    idx++;
                end else begin
                    start = (idx < 256);
                    a = 4'($urandom);
                    b = 4'($urandom);
                end
                @(negedge clk);
                cc++;
            end
            start = 1'b0;
            chk("sweep_timeout", (cc < 3000) ? 1 : 0, 1);
            chk("sweep_done_count", dones, 256);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
